fpu_to_int: RTL and testbench

//  Decoder for the FPU result format {sign[31], exp[30:25], mant[24:0]}, hidden 1, bias EXP_BIAS.

---
 rtl/fpu_to_int_if.sv | 25 ++
 rtl/fpu_to_int.sv | 150 +++++++++++++++
 tb/tb_fpu_to_int.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_to_int_if.sv
// Handshake bundle for the float-to-integer converter: request side (float word in)
// and response side (integer plus one-hot status out).
interface fpu_to_int_if #(
  parameter int INT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      float_in;
  logic             out_valid;
  logic             out_ready;
  logic [INT_W-1:0] int_out;
  logic [3:0]       status_out;
  logic             busy;

  // master: the producer/consumer around the converter; slave: the converter itself
  modport master (
    output in_valid, float_in, out_ready,
    input  in_ready, out_valid, int_out, status_out, busy
  );

  modport slave (
    input  in_valid, float_in, out_ready,
    output in_ready, out_valid, int_out, status_out, busy
  );
endinterface

// File: rtl/fpu_to_int.sv
// Iterative converter from the FPU result format {s, e[5:0], m[24:0]} to a signed integer:
// truncation toward zero, saturation on overflow, one mantissa shift per cycle.
module fpu_to_int #(
  parameter int INT_W    = 32,
  parameter int EXP_BIAS = 31
) (
  input  logic         clock100KHz,
  input  logic         reset,
  fpu_to_int_if.slave  bus
);

  localparam int MAG_W = INT_W - 1;
  localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic signed [6:0] E_TOP  = 7'(INT_W - 1);
  localparam logic signed [6:0] E_UNIT = 7'sd25;

  localparam logic [3:0] ST_EXACT     = 4'b0001;
  localparam logic [3:0] ST_INEXACT   = 4'b0010;
  localparam logic [3:0] ST_OVERFLOW  = 4'b0100;
  localparam logic [3:0] ST_UNDERFLOW = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE, S_CLASSIFY, S_SHIFT, S_FINISH, S_HOLD
  } state_e;

  typedef enum logic [2:0] {
    K_MAG, K_ZERO, K_UNDER, K_MIN, K_OVF
  } kind_e;

  state_e state_q, state_d;

  logic              sign_q;
  logic [5:0]        exp_q;
  logic [24:0]       man_q;
  kind_e             kind_q, cls_kind;
  logic [MAG_W-1:0]  mag_q;
  logic              sticky_q;
  logic [4:0]        cnt_q, cls_cnt;
  logic              left_q, cls_left;
  logic [INT_W-1:0]  int_q;
  logic [3:0]        status_q;
  logic signed [6:0] exp_unb, exp_diff;

  // Classification of the captured word; only consumed in CLASSIFY.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    exp_unb  = $signed({1'b0, exp_q}) - $signed(7'(EXP_BIAS));
    exp_diff = exp_unb - E_UNIT;
    cls_left = exp_unb > E_UNIT;
    cls_cnt  = exp_diff[6] ? 5'(-exp_diff) : 5'(exp_diff);
    cls_kind = K_MAG;
    if (exp_q == 6'd0)                                        cls_kind = K_ZERO;
    else if (exp_unb < 7'sd0)                                 cls_kind = K_UNDER;
    else if (exp_unb == E_TOP && sign_q && man_q == 25'd0)    cls_kind = K_MIN;
    else if (exp_unb >= E_TOP)                                cls_kind = K_OVF;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (bus.in_valid) state_d = S_CLASSIFY;
      S_CLASSIFY: state_d = (cls_kind != K_MAG || cls_cnt == 5'd0) ? S_FINISH : S_SHIFT;
      S_SHIFT:    if (cnt_q == 5'd1) state_d = S_FINISH;
      S_FINISH:   state_d = S_HOLD;
      S_HOLD:     if (bus.out_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock100KHz) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      sign_q   <= 1'b0;
      exp_q    <= '0;
      man_q    <= '0;
      kind_q   <= K_MAG;
      mag_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      int_q    <= '0;
      status_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            sign_q <= bus.float_in[31];
            exp_q  <= bus.float_in[30:25];
            man_q  <= bus.float_in[24:0];
          end
        end
        S_CLASSIFY: begin
          kind_q   <= cls_kind;
          mag_q    <= MAG_W'({1'b1, man_q});
          sticky_q <= 1'b0;
          cnt_q    <= cls_cnt;
          left_q   <= cls_left;
        end
        S_SHIFT: begin
          // Left shifts stop at E = INT_W-2, so the leading one never leaves mag_q.
          if (left_q) begin
            mag_q <= mag_q << 1;
          end else begin
            mag_q    <= mag_q >> 1;
            sticky_q <= sticky_q | mag_q[0];
          end
          cnt_q <= cnt_q - 5'd1;
        end
        S_FINISH: begin
          case (kind_q)
            K_ZERO: begin
              int_q    <= '0;
              status_q <= ST_EXACT;
            end
            K_UNDER: begin
              int_q    <= '0;
              status_q <= ST_UNDERFLOW;
            end
            K_MIN: begin
              int_q    <= INT_MIN;
              status_q <= ST_EXACT;
            end
            K_OVF: begin
              int_q    <= sign_q ? INT_MIN : INT_MAX;
              status_q <= ST_OVERFLOW;
            end
            default: begin
              int_q    <= sign_q ? -{1'b0, mag_q} : {1'b0, mag_q};
              status_q <= sticky_q ? ST_INEXACT : ST_EXACT;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.out_valid  = (state_q == S_HOLD);
  assign bus.int_out    = int_q;
  assign bus.status_out = status_q;

endmodule

// File: tb/tb_fpu_to_int.sv
// Scoreboard bench for fpu_to_int (INT_W=32, EXP_BIAS=31): directed table, randomized
// words against an arithmetic reference model, backpressure hold and mid-conversion reset.
module tb_fpu_to_int;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fpu_to_int_if #(.INT_W(32)) bus ();

  fpu_to_int #(.INT_W(32), .EXP_BIAS(31)) dut (
    .clock100KHz (clk),
    .reset       (reset),
    .bus         (bus)
  );

  typedef struct {
    logic [31:0] f;
    logic [31:0] res;
    logic [3:0]  st;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          bp_mode  = 0;  // 0: out_ready high, 1: random, 2: out_ready low
  logic        prev_valid = 1'b0;
  logic [31:0] last_int;
  logic [3:0]  last_st;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: value = 1.m * 2^E computed with wide integer arithmetic.
  function automatic exp_t model(input logic [31:0] f);
    exp_t   r;
    int     e, big_e;
    longint sig, scaled, ip, frac;
    r.f   = f;
    r.lat = 2;
    r.acc = 0;
    e     = int'(f[30:25]);
    big_e = e - 31;
    sig   = longint'({1'b1, f[24:0]});
    if (e == 0) begin
      r.res = 32'h0; r.st = 4'b0001;
    end else if (big_e < 0) begin
      r.res = 32'h0; r.st = 4'b1000;
    end else if (big_e == 31 && f[31] && f[24:0] == 25'd0) begin
      r.res = 32'h8000_0000; r.st = 4'b0001;
    end else if (big_e >= 31) begin
      r.res = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; r.st = 4'b0100;
    end else begin
      scaled = sig << big_e;
      ip     = scaled >> 25;
      frac   = scaled & ((64'sd1 << 25) - 1);
      r.res  = 32'(f[31] ? -ip : ip);
      r.st   = (frac != 0) ? 4'b0010 : 4'b0001;
      r.lat  = 2 + ((big_e > 25) ? big_e - 25 : 25 - big_e);
    end
    return r;
  endfunction

  // Drives one word; the expectation is queued with the cycle number of its accept edge.
  task automatic send(input exp_t e);
    int t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", {63'd0, bus.in_ready}, 64'd1);
      return;
    end
    e.acc = cyc + 1;
    sb.push_back(e);
    bus.in_valid = 1'b1;
    bus.float_in = e.f;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.float_in = $urandom;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        2:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares on each rising out_valid and checks outputs hold while valid stays high.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(sb.size()), 64'd1);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("int_out[%h]", mon_e.f), 64'(bus.int_out), 64'(mon_e.res));
          check($sformatf("status[%h]", mon_e.f), 64'(bus.status_out), 64'(mon_e.st));
          check($sformatf("latency[%h]", mon_e.f), 64'(cyc - mon_e.acc), 64'(mon_e.lat));
          check("in_ready_in_hold", {63'd0, bus.in_ready}, 64'd0);
        end
      end else if (bus.out_valid && prev_valid) begin
        check("hold_int_stable", 64'(bus.int_out), 64'(last_int));
        check("hold_status_stable", 64'(bus.status_out), 64'(last_st));
      end
      if (bus.out_valid) begin
        last_int = bus.int_out;
        last_st  = bus.status_out;
      end
      prev_valid = bus.out_valid;
    end
  end

  exp_t directed[15] = '{
    '{32'h0000_0000, 32'h0000_0000, 4'b0001,  2, 0},
    '{32'h3E00_0000, 32'h0000_0001, 4'b0001, 27, 0},
    '{32'h3F00_0000, 32'h0000_0001, 4'b0010, 27, 0},
    '{32'hC100_0000, 32'hFFFF_FFFD, 4'b0001, 26, 0},
    '{32'h3C00_0000, 32'h0000_0000, 4'b1000,  2, 0},
    '{32'h7A00_0000, 32'h4000_0000, 4'b0001,  7, 0},
    '{32'hFC00_0000, 32'h8000_0000, 4'b0001,  2, 0},
    '{32'h7E00_0000, 32'h7FFF_FFFF, 4'b0100,  2, 0},
    '{32'hFE00_0000, 32'h8000_0000, 4'b0100,  2, 0},
    '{32'h8000_0000, 32'h0000_0000, 4'b0001,  2, 0},
    '{32'h3E00_0001, 32'h0000_0001, 4'b0010, 27, 0},
    '{32'h7BFF_FFFF, 32'h7FFF_FFE0, 4'b0001,  7, 0},
    '{32'hFBFF_FFFF, 32'h8000_0020, 4'b0001,  7, 0},
    '{32'h7C00_0001, 32'h7FFF_FFFF, 4'b0100,  2, 0},
    '{32'hFC00_0001, 32'h8000_0000, 4'b0100,  2, 0}
  };

  initial begin
    logic [31:0] f;
    int          t;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.float_in = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_int_out", 64'(bus.int_out), 64'd0);
    check("rst_status", 64'(bus.status_out), 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    foreach (directed[i]) send(directed[i]);
    drain();

    bp_mode = 1;
    for (int i = 0; i < 150; i++) begin
      f = $urandom;
      if ($urandom_range(0, 4) != 0) f[30:25] = 6'($urandom_range(28, 63));
      if ($urandom_range(0, 3) == 0) f[24:0] = f[24:0] & (25'h1FF_FFFF << $urandom_range(0, 25));
      send(model(f));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    bp_mode = 2;
    @(negedge clk);
    send(model(32'h7A00_0000));
    t = 0;
    while (!bus.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("hold_reached", {63'd0, bus.out_valid}, 64'd1);
    repeat (10) begin
      @(negedge clk);
      check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
      check("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    bp_mode = 0;
    drain();

    send(model(32'hC100_0000));
    drain();
    send(model(32'h3E00_0000));
    repeat (6) @(negedge clk);
    check("mid_shift_busy", {63'd0, bus.busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("mid_rst_int_out", 64'(bus.int_out), 64'd0);
    check("mid_rst_status", 64'(bus.status_out), 64'd0);
    check("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
    check("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    sb.delete();
    reset = 1'b0;
    send(model(32'h3F00_0000));
    send(model(32'hC100_0000));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
